// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU controller and an IO/DMA requester.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN; otherwise the CPU wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_lock,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              grant_io
);
  typedef enum logic [1:0] {IDLE, CPU_BUSY, IO_BUSY, IO_HOLD} state_t;
  state_t state, next_state;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic req_we, cpu_req, io_req, pick_io, take_cpu, take_io, busy;
  assign cpu_req = cpu_read | cpu_write;
  assign io_req = io_read | io_write;
`ifdef MEM_ARB_RR_EN
  logic last_io;
  assign pick_io = io_req & (~cpu_req | ~last_io);
`else
  assign pick_io = io_req & ~cpu_req;
`endif
  // State register; reset drops any transfer in flight.
  always_ff @(posedge clock)
    state <= !reset ? IDLE : next_state;
  // Next state and grant decisions; requests are only looked at in IDLE and IO_HOLD.
  always_comb begin
    next_state = state;
    take_cpu = 1'b0;
    take_io = 1'b0;
    unique case (state)
      IDLE: begin
        take_io = pick_io;
        take_cpu = cpu_req & ~pick_io;
        next_state = pick_io ? IO_BUSY : cpu_req ? CPU_BUSY : IDLE;
      end
      CPU_BUSY: next_state = mem_ack ? IDLE : CPU_BUSY;
      IO_BUSY: next_state = mem_ack ? (io_lock ? IO_HOLD : IDLE) : IO_BUSY;
      IO_HOLD: begin
        take_io = io_req;
        next_state = io_req ? IO_BUSY : io_lock ? IO_HOLD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
  // Capture the winner's request on the grant edge so later bus changes cannot disturb it.
  always_ff @(posedge clock)
    if (!reset) begin
      req_addr <= '0;
      req_wdata <= '0;
      req_we <= 1'b0;
    end else if (take_io | take_cpu) begin
      req_addr <= take_io ? io_addr : cpu_addr;
      req_wdata <= take_io ? io_wdata : cpu_wdata;
      req_we <= take_io ? io_write : cpu_write;
    end
`ifdef MEM_ARB_RR_EN
  // Remember who won the last fresh arbitration from IDLE for the round-robin tie break.
  always_ff @(posedge clock)
    if (!reset) last_io <= 1'b0;
    else if (take_cpu) last_io <= 1'b0;
    else if (take_io && state == IDLE) last_io <= 1'b1;
`endif
  assign busy = (state == CPU_BUSY) | (state == IO_BUSY);
  assign mem_read = busy & ~req_we;
  assign mem_write = busy & req_we;
  assign mem_addr = busy ? req_addr : '0;
  assign mem_wdata = busy ? req_wdata : '0;
  assign cpu_ack = (state == CPU_BUSY) & mem_ack;
  assign io_ack = (state == IO_BUSY) & mem_ack;
  assign grant_io = (state == IO_BUSY) | (state == IO_HOLD);
  assign rdata = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for locking, bus changes and reset.
module tb_mem_arbiter;
  logic clock = 0, reset = 0;
  logic cpu_read = 0, cpu_write = 0, io_read = 0, io_write = 0, io_lock = 0, mem_ack = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, io_addr = 0, io_wdata = 0, mem_rdata = 0;
  logic cpu_ack, io_ack, mem_read, mem_write, grant_io;
  logic [15:0] rdata, mem_addr, mem_wdata;
  int tests = 0, fails = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .io_read(io_read), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_lock(io_lock), .io_ack(io_ack),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_io(grant_io)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] c, i;
    logic [15:0] ca, cd, ia, id, md;
    logic lk, ma;
    logic [1:0] es;
    logic [15:0] ea, ed;
    logic [2:0] ek;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic [1:0] c, input logic [15:0] ca, cd,
                              input logic [1:0] i, input logic [15:0] ia, id,
                              input logic lk, ma, input logic [15:0] md,
                              input logic [1:0] es, input logic [15:0] ea, ed,
                              input logic [2:0] ek);
    vec_t v;
    v.c = c; v.ca = ca; v.cd = cd; v.i = i; v.ia = ia; v.id = id;
    v.lk = lk; v.ma = ma; v.md = md; v.es = es; v.ea = ea; v.ed = ed; v.ek = ek;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    tv.push_back(mk(2'b10, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(2'b10, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 2'b10, 16'h0010, 0, 3'b000));
    tv.push_back(mk(2'b10, 16'h0010, 0, 0, 0, 0, 0, 1, 16'hBEEF, 2'b10, 16'h0010, 0, 3'b100));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(0, 0, 0, 2'b11, 16'h0005, 16'h5555, 0, 0, 0, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(0, 0, 0, 2'b11, 16'h0005, 16'h5555, 0, 1, 0, 2'b01, 16'h0005, 16'h5555, 3'b011));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(2'b01, 16'h0001, 16'h1111, 2'b01, 16'h0002, 16'h2222, 0, 0, 0, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(2'b01, 16'h0001, 16'h1111, 2'b01, 16'h0002, 16'h2222, 0, 1, 0, 2'b01, 16'h0001, 16'h1111, 3'b100));
    tv.push_back(mk(2'b01, 16'h0001, 16'h1111, 2'b01, 16'h0002, 16'h2222, 0, 0, 0, 2'b00, 0, 0, 3'b000));
`ifdef MEM_ARB_RR_EN
    tv.push_back(mk(2'b01, 16'h0001, 16'h1111, 2'b01, 16'h0002, 16'h2222, 0, 1, 0, 2'b01, 16'h0002, 16'h2222, 3'b011));
`else
    tv.push_back(mk(2'b01, 16'h0001, 16'h1111, 2'b01, 16'h0002, 16'h2222, 0, 1, 0, 2'b01, 16'h0001, 16'h1111, 3'b100));
`endif
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 2'b00, 0, 0, 3'b000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000));

    // reset with a pending request: everything stays quiet
    cpu_read = 1; cpu_addr = 16'h0099;
    next_cycle(); next_cycle();
    @(negedge clock);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {cpu_ack, io_ack, grant_io}, 0);
    cpu_read = 0; cpu_addr = 0;
    next_cycle();
    reset = 1;
    next_cycle();

    foreach (tv[n]) begin
      v = tv[n];
      {cpu_read, cpu_write} = v.c; cpu_addr = v.ca; cpu_wdata = v.cd;
      {io_read, io_write} = v.i; io_addr = v.ia; io_wdata = v.id;
      io_lock = v.lk; mem_ack = v.ma; mem_rdata = v.md;
      @(negedge clock);
      chk($sformatf("v%0d_strobes", n), {mem_read, mem_write}, v.es);
      if (v.es != 0) begin
        chk($sformatf("v%0d_addr", n), mem_addr, v.ea);
        if (v.es[0]) chk($sformatf("v%0d_wdata", n), mem_wdata, v.ed);
      end
      chk($sformatf("v%0d_acks", n), {cpu_ack, io_ack, grant_io}, v.ek);
      chk($sformatf("v%0d_rdata", n), rdata, v.md);
      next_cycle();
    end

    // IO locked burst of four writes while CPU keeps requesting a read
    io_write = 1; io_addr = 16'h0100; io_wdata = 16'hA000; io_lock = 1;
    @(negedge clock);
    chk("lk_idle_grant", grant_io, 0);
    next_cycle();
    cpu_read = 1; cpu_addr = 16'h0777;
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1;
      @(negedge clock);
      chk($sformatf("lk%0d_strobes", k), {mem_read, mem_write}, 2'b01);
      chk($sformatf("lk%0d_addr", k), mem_addr, 16'h0100 + 16'(k));
      chk($sformatf("lk%0d_wdata", k), mem_wdata, 16'hA000 + 16'(k));
      chk($sformatf("lk%0d_acks", k), {cpu_ack, io_ack, grant_io}, 3'b011);
      next_cycle();
      mem_ack = 0;
      if (k < 3) begin
        io_addr = 16'h0100 + 16'(k + 1); io_wdata = 16'hA000 + 16'(k + 1);
        @(negedge clock);
        chk($sformatf("lk%0d_hold", k), {mem_read, mem_write, cpu_ack, grant_io}, 4'b0001);
        next_cycle();
      end
    end
    io_write = 0;
    @(negedge clock);
    chk("lk_hold_locked", {mem_read, mem_write, grant_io}, 3'b001);
    next_cycle();
    io_lock = 0;
    @(negedge clock);
    chk("lk_unlock_cycle", {mem_read, grant_io}, 2'b01);
    next_cycle();
    @(negedge clock);
    chk("lk_idle_bubble", {mem_read, grant_io}, 2'b00);
    next_cycle();
    mem_ack = 1; mem_rdata = 16'h4242;
    @(negedge clock);
    chk("lk_cpu_read", {mem_read, mem_write}, 2'b10);
    chk("lk_cpu_addr", mem_addr, 16'h0777);
    chk("lk_cpu_ack", {cpu_ack, io_ack, grant_io}, 3'b100);
    chk("lk_cpu_rdata", rdata, 16'h4242);
    next_cycle();
    cpu_read = 0; mem_ack = 0;
    next_cycle();

    // IO bus changes after grant; memory acks three cycles late
    io_read = 1; io_addr = 16'h0200;
    next_cycle();
    io_addr = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("chg%0d_addr", k), mem_addr, 16'h0200);
      chk($sformatf("chg%0d_state", k), {mem_read, io_ack, grant_io}, 3'b101);
      next_cycle();
    end
    mem_ack = 1; mem_rdata = 16'h0C0C;
    @(negedge clock);
    chk("chg_ack_addr", mem_addr, 16'h0200);
    chk("chg_ack", {mem_read, cpu_ack, io_ack}, 3'b101);
    next_cycle();
    io_read = 0; mem_ack = 0; io_addr = 0;
    next_cycle();

    // reset during CPU_BUSY, then a late memory ack
    cpu_read = 1; cpu_addr = 16'h0030;
    next_cycle();
    @(negedge clock);
    chk("rb_busy", mem_read, 1);
    reset = 0;
    next_cycle();
    cpu_read = 0; mem_ack = 1;
    @(negedge clock);
    chk("rb_dropped", {mem_read, mem_write, cpu_ack, io_ack, grant_io}, 0);
    chk("rb_addr", mem_addr, 0);
    next_cycle();
    reset = 1;
    @(negedge clock);
    chk("rb_late_ack", {mem_read, cpu_ack, io_ack}, 0);
    next_cycle();
    mem_ack = 0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single Sextium III memory port between the CPU controller (fetch/load/store) and an IO/DMA requester. Each requester uses the same level-request/ack-pulse handshake the controller already drives. Requests are latched at grant and replayed to memory, so a requester's bus may change after grant without corrupting the transfer. An IO lock lets a DMA engine hold the port across back-to-back transfers.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 16, data word width

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; state cleared on the rising edge while low
- cpu_read, cpu_write  in  1 each  CPU request strobes, held until cpu_ack
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- io_read, io_write  in  1 each  IO request strobes, held until io_ack
- io_addr  in  ADDR_W;  io_wdata  in  DATA_W
- io_lock  in  1  keep IO grant after current transfer
- io_ack  out  1  one-cycle completion pulse to IO
- rdata  out  DATA_W  mem_rdata passed through to both requesters
- mem_read, mem_write  out  1 each  memory strobes
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W;  mem_ack  in  1  memory completion pulse
- grant_io  out  1  1 while IO owns the port (IO_BUSY or IO_HOLD)

## Operation
- States: IDLE, CPU_BUSY, IO_BUSY, IO_HOLD.
- IDLE: sample requests. Request = read|write. Winner chosen by the priority rule; the winner's addr, wdata and type are latched into req_addr/req_wdata/req_we; go to <winner>_BUSY. No request: stay.
- Read and write asserted together by one requester: treated as a write.
- CPU_BUSY/IO_BUSY: mem_read = ~req_we, mem_write = req_we, mem_addr/mem_wdata from latches. On mem_ack: pulse the owner's ack the same cycle (combinational). Next state: IO_HOLD if the owner is IO and io_lock=1; otherwise IDLE.
- IO_HOLD: memory strobes low; CPU requests are not granted. An IO request latches and goes to IO_BUSY. io_lock=0 with no IO request: go to IDLE.
- mem_ack outside a BUSY state: ignored, no ack forwarded.
- Requests are sampled only in IDLE/IO_HOLD, so a request still high in its own ack cycle is never served twice.
- last_io register: set to 1 on IO grant from IDLE, 0 on CPU grant; used only by round-robin.
- Reset: state=IDLE, last_io=0, latches cleared. All outputs 0: mem_read, mem_write, cpu_ack, io_ack, grant_io, mem_addr, mem_wdata. rdata follows mem_rdata. Reset mid-transfer drops the strobes on the next edge; a late mem_ack is ignored.

## Timing
- Request first high in IDLE at cycle N: strobes high at N+1. Minimum read or write is 2 cycles with same-cycle mem_ack.
- Owner ack is in the same cycle as mem_ack. rdata is valid in that cycle.
- One IDLE bubble cycle between transfers. IO_HOLD → IO_BUSY has the same 1-cycle latency.
- Latches are written only on the grant edge. Requester bus changes after grant have no effect.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. When both request in IDLE, grant IO if last_io=0, else CPU.
- MEM_ARB_RR_EN undefined: fixed priority. The CPU always wins a tie, and last_io is not implemented. IO can be starved by continuous CPU traffic; this is accepted.

## Test plan
- CPU read at 0x0010 only, memory acks 1 cycle after strobe with 0xBEEF → mem_read high at N+1, cpu_ack and rdata=0xBEEF at N+2, io_ack never high.
- CPU and IO both write in the same cycle (cpu 0x0001←0x1111, io 0x0002←0x2222), repeated twice → without RR_EN: CPU, CPU. With RR_EN: CPU then IO.
- IO writes 0x0100..0x0103 with io_lock=1 while CPU holds cpu_read → all four IO transfers complete before the CPU grant. CPU is granted the cycle after io_lock falls in IO_HOLD.
- IO changes io_addr from 0x0200 to 0x0300 after grant, before a 3-cycle-late mem_ack → mem_addr stays 0x0200 throughout.
- Spurious mem_ack in IDLE → no ack pulses, state unchanged.
- Reset low during CPU_BUSY → mem_read=0 next cycle. A mem_ack arriving after reset yields no cpu_ack.
- Requester asserting read and write together at 0x0005 → memory sees a write only; mem_read stays 0.
